// File: rtl/countdown_timer_pkg.sv
// clock_pkg: BCD digit/time types, digit limits, timer states, load check.
// Shared by the clock and countdown blocks.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hour_10;
    bcd_t hour_unit;
    bcd_t min_10;
    bcd_t min_unit;
    bcd_t sec_10;
    bcd_t sec_unit;
  } time_t;

  localparam int HOUR_10_LSB   = 20;
  localparam int HOUR_UNIT_LSB = 16;
  localparam int MIN_10_LSB    = 12;
  localparam int MIN_UNIT_LSB  = 8;
  localparam int SEC_10_LSB    = 4;
  localparam int SEC_UNIT_LSB  = 0;

  localparam int SEC_10_MAX  = 5;
  localparam int MIN_10_MAX  = 5;
  localparam int UNIT_MAX    = 9;
  localparam int HOUR_MAX    = 23;
  localparam int HOUR_10_MAX = HOUR_MAX / 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } tstate_t;

  function automatic logic time_valid(time_t t);
    logic hr_ok;
    hr_ok = (t.hour_10 < 4'(HOUR_10_MAX)
             && t.hour_unit <= 4'(UNIT_MAX))
         || (t.hour_10 == 4'(HOUR_10_MAX)
             && t.hour_unit <= 4'(HOUR_MAX % 10));
    return hr_ok
        && t.min_10   <= 4'(MIN_10_MAX)
        && t.min_unit <= 4'(UNIT_MAX)
        && t.sec_10   <= 4'(SEC_10_MAX)
        && t.sec_unit <= 4'(UNIT_MAX);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Countdown timer control/status bundle.
// master: load/load_time/start/stop out; slave: time_out/running/done/load_err out.
interface countdown_timer_if
  import clock_pkg::*;
();
  logic  load;
  time_t load_time;
  logic  start;
  logic  stop;
  time_t time_out;
  logic  running;
  logic  done;
  logic  load_err;

  modport master (
    output load, load_time, start, stop,
    input  time_out, running, done, load_err
  );

  modport slave (
    input  load, load_time, start, stop,
    output time_out, running, done, load_err
  );
endinterface

// File: rtl/countdown_timer_bcd_digit_dec.sv
// bcd_digit_dec: one BCD digit of the decrement ripple chain.
// digit/borrow_in -> digit_next/borrow_out; wraps 0 to MAX on borrow.
module bcd_digit_dec
  import clock_pkg::*;
#(
  parameter int MAX = 9
) (
  input  bcd_t digit,
  input  logic borrow_in,
  output bcd_t digit_next,
  output logic borrow_out
);
  logic zero;

  assign zero       = (digit == 4'd0);
  assign borrow_out = borrow_in & zero;
  assign digit_next = !borrow_in ? digit
                    : zero       ? 4'(MAX)
                    : digit - 4'd1;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: BCD HH:MM:SS countdown, clk/rst_n plus slave bus.
// `define COUNTDOWN_AUTO_RELOAD_EN reloads the preset at expiry.
module countdown_timer
  import clock_pkg::*;
#(
  parameter int CLKS_PER_SEC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  countdown_timer_if.slave   bus
);
  localparam int PW =
    (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_SEC - 1);

  tstate_t       state;
  time_t         cur;
  logic [PW-1:0] presc;
  logic          running;
  logic          done;
  logic          load_err;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  time_t         preset;
`endif

  time_t      dec;
  logic [6:0] brw;
  logic       underflow;

  assign brw[0] = 1'b1;

  // Digit 0 is sec_unit; limits follow the HH:MM:SS digit ranges.
  for (genvar i = 0; i < 6; i++) begin : g_dec
    localparam int M =
      (i == 1) ? SEC_10_MAX :
      (i == 3) ? MIN_10_MAX :
      (i == 5) ? HOUR_10_MAX : UNIT_MAX;
    bcd_digit_dec #(.MAX(M)) u_dig (
      .digit      (cur[4*i +: 4]),
      .borrow_in  (brw[i]),
      .digit_next (dec[4*i +: 4]),
      .borrow_out (brw[i+1])
    );
  end

  // Borrow out of hour_10 means cur was already zero; treat as expiry.
  assign underflow = brw[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      presc    <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      preset   <= '0;
`endif
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (bus.load) begin
        if (time_valid(bus.load_time)) begin
          cur     <= bus.load_time;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          preset  <= bus.load_time;
`endif
          state   <= IDLE;
          presc   <= '0;
          running <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (bus.stop) begin
        if (state == RUN) begin
          state   <= PAUSED;
          running <= 1'b0;
        end
      end else begin
        unique case (1'b1)
          (state == IDLE): begin
            if (bus.start) begin
              if (cur != '0) begin
                state   <= RUN;
                presc   <= '0;
                running <= 1'b1;
              end else begin
                state <= EXPIRED;
                done  <= 1'b1;
              end
            end
          end
          (state == PAUSED): begin
            if (bus.start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          (state == RUN): begin
            if (presc == PMAX) begin
              presc <= '0;
              if (dec == '0 || underflow) begin
                done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                cur <= preset;
`else
                cur     <= '0;
                state   <= EXPIRED;
                running <= 1'b0;
`endif
              end else begin
                cur <= dec;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.time_out = cur;
  assign bus.running  = running;
  assign bus.done     = done;
  assign bus.load_err = load_err;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer, CLKS_PER_SEC=4.
// Per-scenario tasks push expected outputs and compare after each edge.
module tb_countdown_timer;
  import clock_pkg::*;

  localparam int CPS = 4;

  typedef struct packed {
    logic [23:0] t;
    logic        run;
    logic        done;
    logic        err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  obs_t q[$];

  countdown_timer_if bus();

  countdown_timer #(.CLKS_PER_SEC(CPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic obs_t mk(logic [23:0] t, logic r,
                              logic d, logic e);
    obs_t o;
    o.t = t; o.run = r; o.done = d; o.err = e;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.time_out, bus.running, bus.done, bus.load_err);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic ld, logic [23:0] t,
                       logic st, logic sp);
    bus.load = ld;
    bus.load_time = t;
    bus.start = st;
    bus.stop = sp;
  endtask

  task automatic test_reset();
    obs_t o, e;
    drive(0, 24'h0, 0, 0);
    #12;
    q.push_back(mk(24'h0, 0, 0, 0));
    e = q.pop_front(); o = sample(); total++;
    if (o !== e) $display("FAIL reset_init got %h want %h", o, e);
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    drive(1, 24'h000007, 0, 0); tick();
    drive(0, 24'h0, 1, 0); tick();
    drive(0, 24'h0, 0, 0);
    repeat (3) tick();
    q.push_back(mk(24'h000007, 1, 0, 0));
    q.push_back(mk(24'h0, 0, 0, 0));
    q.push_back(mk(24'h0, 0, 1, 0));
    q.push_back(mk(24'h0, 0, 0, 0));
    q.push_back(mk(24'h0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin #2; rst_n = 1'b0; #1; end
      if (i == 2) begin
        @(negedge clk) rst_n = 1'b1;
        drive(0, 24'h0, 1, 0); tick();
        drive(0, 24'h0, 0, 0);
      end
      if (i == 3) tick();
      if (i == 4) begin
        drive(0, 24'h0, 1, 0); tick();
        drive(0, 24'h0, 0, 0);
      end
      e = q.pop_front(); o = sample(); total++;
      if (o !== e)
        $display("FAIL reset[%0d] t=%h run=%b done=%b err=%b want t=%h run=%b done=%b err=%b",
                 i, o.t, o.run, o.done, o.err, e.t, e.run, e.done, e.err);
      else passed++;
    end
  endtask

`ifndef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_countdown();
    obs_t o, e;
    logic [23:0] t;
    drive(1, 24'h000003, 0, 0); tick();
    drive(0, 24'h0, 1, 0); tick();
    drive(0, 24'h0, 0, 0);
    q.push_back(mk(24'h000003, 1, 0, 0));
    for (int k = 1; k <= 14; k++) begin
      t = (k < 4) ? 24'h3 : (k < 8) ? 24'h2 : (k < 12) ? 24'h1 : 24'h0;
      q.push_back(mk(t, k < 12, k == 12, 0));
    end
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) tick();
      e = q.pop_front(); o = sample(); total++;
      if (o !== e)
        $display("FAIL countdown[%0d] t=%h run=%b done=%b err=%b want t=%h run=%b done=%b err=%b",
                 k, o.t, o.run, o.done, o.err, e.t, e.run, e.done, e.err);
      else passed++;
    end
  endtask
`else
  task automatic test_auto_reload();
    obs_t o, e;
    logic [23:0] t;
    drive(1, 24'h000002, 0, 0); tick();
    drive(0, 24'h0, 1, 0); tick();
    drive(0, 24'h0, 0, 0);
    for (int k = 0; k <= 26; k++) begin
      t = ((k % 8) < 4) ? 24'h2 : 24'h1;
      q.push_back(mk(t, 1, k > 0 && (k % 8) == 0, 0));
    end
    for (int k = 0; k <= 26; k++) begin
      if (k > 0) tick();
      e = q.pop_front(); o = sample(); total++;
      if (o !== e)
        $display("FAIL reload[%0d] t=%h run=%b done=%b err=%b want t=%h run=%b done=%b err=%b",
                 k, o.t, o.run, o.done, o.err, e.t, e.run, e.done, e.err);
      else passed++;
    end
  endtask
`endif

  task automatic test_borrow();
    obs_t o, e;
    logic [23:0] pre [5] = '{24'h010000, 24'h100000, 24'h001000,
                             24'h200000, 24'h000100};
    logic [23:0] nxt [5] = '{24'h005959, 24'h095959, 24'h000959,
                             24'h195959, 24'h000059};
    for (int c = 0; c < 5; c++) begin
      drive(1, pre[c], 0, 0); tick();
      drive(0, 24'h0, 1, 0); tick();
      drive(0, 24'h0, 0, 0);
      for (int k = 1; k <= 4; k++)
        q.push_back(mk((k < 4) ? pre[c] : nxt[c], 1, 0, 0));
      for (int k = 1; k <= 4; k++) begin
        tick();
        e = q.pop_front(); o = sample(); total++;
        if (o !== e)
          $display("FAIL borrow[%0d.%0d] t=%h run=%b done=%b err=%b want t=%h run=%b done=%b err=%b",
                   c, k, o.t, o.run, o.done, o.err, e.t, e.run, e.done, e.err);
        else passed++;
      end
    end
  endtask

  task automatic test_invalid_load();
    obs_t o, e;
    logic [23:0] bad [5] = '{24'h240000, 24'h006000, 24'h00005A,
                             24'h300000, 24'h000A00};
    drive(1, 24'h123456, 0, 0); tick();
    drive(0, 24'h0, 0, 0);
    q.push_back(mk(24'h123456, 0, 0, 0));
    for (int c = 0; c < 5; c++) begin
      q.push_back(mk(24'h123456, 0, 0, 1));
      q.push_back(mk(24'h123456, 0, 0, 0));
    end
    q.push_back(mk(24'h123456, 1, 0, 0));
    q.push_back(mk(24'h235959, 0, 0, 0));
    for (int i = 0; i < 13; i++) begin
      if (i >= 1 && i <= 10) begin
        if (i % 2 == 1) drive(1, bad[(i-1)/2], 0, 0);
        tick();
        drive(0, 24'h0, 0, 0);
      end
      if (i == 11) begin
        drive(0, 24'h0, 1, 0); tick();
        drive(0, 24'h0, 0, 0);
      end
      if (i == 12) begin
        drive(1, 24'h235959, 0, 0); tick();
        drive(0, 24'h0, 0, 0);
      end
      e = q.pop_front(); o = sample(); total++;
      if (o !== e)
        $display("FAIL invalid_load[%0d] t=%h run=%b done=%b err=%b want t=%h run=%b done=%b err=%b",
                 i, o.t, o.run, o.done, o.err, e.t, e.run, e.done, e.err);
      else passed++;
    end
  endtask

  task automatic test_pause();
    obs_t o, e;
    drive(1, 24'h000010, 0, 0); tick();
    drive(0, 24'h0, 1, 0); tick();
    drive(0, 24'h0, 0, 0);
    repeat (6) tick();
    drive(0, 24'h0, 0, 1); tick();
    drive(0, 24'h0, 0, 0);
    for (int i = 0; i <= 20; i++) q.push_back(mk(24'h9, 0, 0, 0));
    q.push_back(mk(24'h9, 1, 0, 0));
    q.push_back(mk(24'h9, 1, 0, 0));
    q.push_back(mk(24'h8, 1, 0, 0));
    q.push_back(mk(24'h8, 0, 0, 0));
    for (int i = 0; i <= 5; i++) q.push_back(mk(24'h5, 0, 0, 0));
    for (int i = 0; i < 30; i++) begin
      if (i == 21) drive(0, 24'h0, 1, 0);
      if (i == 24) drive(0, 24'h0, 1, 1);
      if (i == 25) drive(1, 24'h000005, 1, 0);
      if (i > 0) tick();
      drive(0, 24'h0, 0, 0);
      e = q.pop_front(); o = sample(); total++;
      if (o !== e)
        $display("FAIL pause[%0d] t=%h run=%b done=%b err=%b want t=%h run=%b done=%b err=%b",
                 i, o.t, o.run, o.done, o.err, e.t, e.run, e.done, e.err);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    test_countdown();
`else
    test_auto_reload();
`endif
    test_borrow();
    test_invalid_load();
    test_pause();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- BCD HH:MM:SS countdown timer; the decrementing counterpart of the free-running digital clock counter.
- Loads a preset time, counts down once per second on a prescaled clock, and flags expiry.
- Sits beside the clock block, sharing its BCD digit format; drives the display path and the alarm/beeper logic.

Parameters:
CLKS_PER_SEC, 1, clk cycles per one-second decrement (>=1; prescaler width = clog2, min 1)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
load  input  1  load load_time (validated) this cycle
load_time  input  24  preset, 6 BCD digits: [23:20] hour_10, [19:16] hour_unit, [15:12] min_10, [11:8] min_unit, [7:4] sec_10, [3:0] sec_unit
start  input  1  begin/resume counting
stop  input  1  pause counting
time_out  output  24  current remaining time, same packing as load_time
running  output  1  high in RUN
done  output  1  one-cycle pulse at expiry
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Clocking/reset: one clock. Reset is asynchronous, active-low, named rst_n; clock named clk.
- Reset values: time_out=0, running=0, done=0, load_err=0, prescaler=0, preset register=0, state=IDLE.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Load validation:
  - Valid iff hour_10<=2, hour_unit<=9, hours<=23, min_10<=5, min_unit<=9, sec_10<=5, sec_unit<=9.
  - Valid load in any state: time_out and preset register take load_time next edge; state becomes IDLE; prescaler cleared.
  - Invalid load: load_err=1 for one cycle; time_out, preset and state unchanged.
- Priority per cycle: load > stop > start.
  - load with start in the same cycle: load applied, start ignored.
  - start with stop in the same cycle: stop wins.
- Transitions:
  - IDLE + start: RUN if time_out!=0; otherwise EXPIRED with done=1 next edge.
  - RUN + stop: PAUSED, prescaler frozen.
  - PAUSED + start: RUN, prescaler continues from frozen value.
  - EXPIRED: holds 00:00:00, running=0. Only load leaves it; start is ignored.
- Counting:
  - Prescaler increments each cycle in RUN; entering RUN from IDLE clears it.
  - When prescaler==CLKS_PER_SEC-1, prescaler wraps to 0 and time_out decrements by one second on that edge.
  - First decrement occurs CLKS_PER_SEC cycles after the start edge.
- BCD decrement with borrow chain:
  - sec_unit 0->9 borrows sec_10; sec_10 0->5 borrows min_unit.
  - min_unit 0->9 borrows min_10; min_10 0->5 borrows hour_unit.
  - hour_unit 0->9 borrows hour_10.
  - No binary intermediate values; each digit stays 4-bit BCD.
- Expiry: on the decrement edge where the result is 00:00:00:
  - state becomes EXPIRED, done=1 for exactly that cycle, running=0 the same cycle.
- Reset mid-count: immediate return to reset values; the preset is lost.
- running is registered and equals (state==RUN).

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: at expiry, done pulses and time_out reloads the preset register on the same edge instead of going to 00:00:00. State stays RUN; prescaler wraps normally, giving a periodic timer. A preset of 00:00:00 still enters EXPIRED.
- Undefined: behaviour as above; the preset register may be optimised away.

Decomposition:
- Shared package clock_pkg:
  - BCD digit typedef (4 bits); packed time typedef (24 bits) with field offsets.
  - Digit limit constants: SEC_10_MAX=5, MIN_10_MAX=5, UNIT_MAX=9, HOUR_MAX=23.
  - Timer state enum.
- One sub-module, bcd_digit_dec:
  - Parameter MAX; inputs digit and borrow_in; outputs next digit and borrow_out.
  - Instantiated six times as a ripple chain.

Test Plan (CLKS_PER_SEC=4):
- Reset asserted mid-RUN at 00:00:07 -> time_out=0, running=0, done=0 immediately (asynchronously); start after release -> EXPIRED, done pulse next edge.
- Load 00:00:03, start -> time_out 02,01,00 at cycles 4,8,12 after start; done high only at cycle 12; running low from cycle 12.
- Load 01:00:00, start -> after 4 cycles time_out=00:59:59; load 10:00:00 -> after 4 cycles 09:59:59.
- Load 24:00:00, then 00:60:00, then 00:00:5A -> load_err pulses three times; time_out keeps its prior value; state unchanged.
- Load 00:00:10, start, stop at cycle 6 (value 00:00:09) -> holds for 20 cycles; start -> 00:00:08 exactly 2 cycles later (frozen prescaler=2). Load+start in the same cycle -> loaded, remains IDLE.
- With COUNTDOWN_AUTO_RELOAD_EN, load 00:00:02, start -> done pulses at cycles 8, 16, 24; time_out sequence 01,02,01,02; running stays 1.
